// File: rtl/l2_block_adapter.sv
// Block-to-word adapter between the bus controller and the L2 memory port.
// Serialises one block request into busy-handshaked word beats with a per-beat watchdog.
module l2_block_adapter #(
    parameter int unsigned BLOCK_SIZE_WORDS = 2,
    parameter int unsigned WORD_W           = 32,
    parameter int unsigned ADDR_W           = 32,
    parameter int unsigned TIMEOUT          = 25
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               l2_req,
    input  logic                               l2_rw,
    input  logic [ADDR_W-1:0]                  l2_addr,
    input  logic [BLOCK_SIZE_WORDS*WORD_W-1:0] l2_store,
    output logic [BLOCK_SIZE_WORDS*WORD_W-1:0] l2_load,
    output logic                               l2_done,
    output logic                               l2_err,
    output logic                               mem_ren,
    output logic                               mem_wen,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [WORD_W-1:0]                  mem_wdata,
    input  logic [WORD_W-1:0]                  mem_rdata,
    input  logic                               mem_busy
);

    localparam int unsigned BLK_W      = BLOCK_SIZE_WORDS * WORD_W;
    localparam int unsigned WORD_BYTES = WORD_W / 8;
    localparam int unsigned OFF_W      = $clog2(BLK_W / 8);
    localparam int unsigned BEAT_W     = (BLOCK_SIZE_WORDS > 1) ? $clog2(BLOCK_SIZE_WORDS) : 1;
    localparam int unsigned WD_W       = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] BASE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_SIZE_WORDS - 1);

    typedef logic [BLOCK_SIZE_WORDS-1:0][WORD_W-1:0] block_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               rw_q, rw_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    block_t             store_q, store_d;
    block_t             buf_q, buf_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;

    logic [ADDR_W-1:0]  beat_addr;
    logic [WD_W-1:0]    wdog_inc;

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            rw_q    <= 1'b0;
            base_q  <= '0;
            store_q <= '0;
            buf_q   <= '0;
            beat_q  <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            base_q  <= base_d;
            store_q <= store_d;
            buf_q   <= buf_d;
            beat_q  <= beat_d;
            wdog_q  <= wdog_d;
        end
    end

    // Next-state, beat sequencing and port outputs
    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        base_d    = base_q;
        store_d   = store_q;
        buf_d     = buf_q;
        beat_d    = beat_q;
        wdog_d    = wdog_q;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        l2_done   = 1'b0;
        l2_err    = 1'b0;
        l2_load   = buf_q;
        beat_addr = base_q + ADDR_W'(beat_q) * ADDR_W'(WORD_BYTES);
        wdog_inc  = wdog_q + WD_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (l2_req) begin
                    state_d = S_XFER;
                    rw_d    = l2_rw;
                    base_d  = l2_addr & BASE_MASK;
                    store_d = l2_store;
                    buf_d   = '0;
                    beat_d  = '0;
                    wdog_d  = '0;
                end
            end
            S_XFER: begin
                mem_ren  = ~rw_q;
                mem_wen  = rw_q;
                mem_addr = beat_addr;
                if (rw_q) begin
                    mem_wdata = store_q[beat_q];
                end
                if (!mem_busy) begin
                    if (!rw_q) begin
                        buf_d[beat_q] = mem_rdata;
                    end
                    wdog_d = '0;
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_DONE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end else begin
                    // Stalled beat: abort once the busy streak reaches TIMEOUT
                    wdog_d = wdog_inc;
                    if (wdog_inc == WD_W'(TIMEOUT)) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_DONE: begin
                l2_done = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                l2_done = 1'b1;
                l2_err  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/l2_block_adapter.md
# l2_block_adapter

Downstream stage of the bus controller: accepts one block-granular L2 request (read or write of BLOCK_SIZE_WORDS words) from bus_ctrl and serialises it into word-granular transactions on the L2 memory port, which uses busy-based handshaking. It buffers the block, generates per-word addresses, collects read beats and returns the assembled block with a one-cycle completion pulse. A per-beat watchdog aborts a transfer stuck on `mem_busy` and flags an error, so the bus controller never hangs on a dead L2.

## Interface
- BLOCK_SIZE_WORDS, 2, words per coherence block; power of two, ≥1
- WORD_W, 32, data word width
- ADDR_W, 32, byte address width
- TIMEOUT, 25, max consecutive busy cycles per beat before abort; ≥1
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset; synchronous, active-high
- l2_req  in  1  bus_ctrl request; level, held until `l2_done` observed
- l2_rw  in  1  0 = block read, 1 = block write; sampled on accept
- l2_addr  in  ADDR_W  block byte address; sampled on accept
- l2_store  in  BLOCK_SIZE_WORDS*WORD_W  write block, word i in bits [i*WORD_W +: WORD_W]; sampled on accept
- l2_load  out  BLOCK_SIZE_WORDS*WORD_W  read block; valid while `l2_done`=1 and `l2_err`=0
- l2_done  out  1  one-cycle completion pulse (success or abort)
- l2_err  out  1  one-cycle abort flag, coincident with `l2_done`
- mem_ren  out  1  word read request
- mem_wen  out  1  word write request
- mem_addr  out  ADDR_W  word byte address
- mem_wdata  out  WORD_W  write data
- mem_rdata  in  WORD_W  read data; valid in the cycle a read beat completes
- mem_busy  in  1  L2 stall; a beat completes in a cycle with (ren|wen)=1 and busy=0

## Operation
- States: IDLE, XFER, DONE, ERR.
- IDLE: if `l2_req`=1, accept on that edge. Latch rw, base = `l2_addr` with low $clog2(BLOCK_SIZE_WORDS*WORD_W/8) bits forced to 0, and store block. Clear read buffer to 0, beat = 0, wdog = 0. Go to XFER.
- XFER: `mem_ren` = ~rw and `mem_wen` = rw, both combinational from state. `mem_addr` = base + beat*(WORD_W/8). `mem_wdata` = store word[beat] on writes, else 0.
  - Busy=0: beat completes. On reads, buffer[beat] ← `mem_rdata`. wdog ← 0. Last beat → DONE, otherwise beat+1.
  - Busy=1: wdog+1. If wdog+1 = TIMEOUT → ERR.
- DONE: `l2_done`=1, `l2_load`=buffer. Next state IDLE unconditionally, so no accept is possible in the DONE cycle.
- ERR: `l2_done`=1, `l2_err`=1, `l2_load`=buffer (partial; words never received read as 0). `mem_ren`/`mem_wen`=0. Next state IDLE.
- `l2_load` holds the buffer contents in every state. Its value is only meaningful in DONE.
- Requester protocol: `l2_req` drops on the edge after it sees `l2_done`. If `l2_req` is still 1 in the following IDLE cycle, a new transaction is accepted.
- Changes to `l2_rw`/`l2_addr`/`l2_store` after accept are ignored.
- Address arithmetic wraps modulo 2^ADDR_W. Beat counter width is max(1,$clog2(BLOCK_SIZE_WORDS)). wdog width is $clog2(TIMEOUT+1).

## Timing
- Reset values: state IDLE, all outputs 0, buffer 0, counters 0.
- RST asserted mid-transfer: `mem_ren`/`mem_wen` are 0 in the cycle after the edge, and no `l2_done` is produced for the abandoned request.
- Zero-stall latency: accept on edge E0, beat i is presented in cycle i after E0, and `l2_done` is high BLOCK_SIZE_WORDS+1 cycles after the accepting edge (3 for the default).
- Each busy cycle adds exactly one cycle.
- Abort: `l2_err` goes high the cycle after the TIMEOUT-th consecutive busy cycle of a single beat. A completed beat resets the count.
- At most one transaction in flight. Back-to-back minimum spacing is BLOCK_SIZE_WORDS+2 cycles, accept to accept.

## Test plan
- Read, no stalls: l2_addr=0x1004, rw=0, rdata 0xAAAA0001 then 0xAAAA0002 → mem_addr 0x1000, 0x1004; `l2_done` 3 cycles after accept; l2_load={0xAAAA0002,0xAAAA0001}; l2_err=0.
- Write with stalls: store {0x22,0x11} at 0x2000, busy=1 for 2 cycles on beat 0 → wdata 0x11@0x2000 held 3 cycles, then 0x22@0x2004; done at accept+5.
- Timeout: busy stuck 1 on beat 1 of a read → ERR after 25 busy cycles; l2_done=l2_err=1 for one cycle; l2_load word1=0, word0=beat-0 data; ren drops the same cycle.
- Watchdog per beat: 24 busy cycles on each beat → completes with no error.
- Reset mid-XFER: assert RST during beat 1 → ren/wen=0 next cycle, no done pulse; fresh request afterwards completes normally.
- Back-to-back: req held high through done → second accept occurs in the IDLE cycle right after DONE; new address is latched and the old store data is not reused.
